// File: rtl/mul16_share_arb.sv
// rtl/mul16_share_arb.sv - round-robin arbiter sharing one pipelined 16x16 multiplier among NREQ requesters
//
// Optional build macro: MUL_SHARE_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest requester index wins, no rotating pointer
//   undefined -> round-robin starting at a rotating priority pointer
//
// The multiplier itself lives outside this block. Operands are driven
// combinationally in the grant cycle. A tag pipeline of the same depth as the
// multiplier follows each product, so the product is steered back to the
// requester that issued it.

module mul16_share_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arb_en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 mul_ce,
    output logic                 mul_rst,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_p,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_p,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // run_q rises on the first clock edge after reset release; it gates grants
    // and the multiplier enable so that reset exit is synchronous to clk.
    logic           run_q;

    // Arbitration result for this cycle.
    logic           grant_any;
    logic [PW-1:0]  grant_idx;
    logic           grant_en;

    // Tag pipeline: one entry per multiplier stage.
    logic           tag_vld [LAT];
    logic [PW-1:0]  tag_idx [LAT];

    // Leave the reset domain on the first clock edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN

    // Fixed priority: scan from the top so the lowest valid index is kept last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = PW'(i);
            end
        end
    end

`else

    logic [PW-1:0]  ptr;

    // Round-robin: scan offsets from ptr downward so the smallest offset
    // (closest to ptr, ascending with wrap) is the one that survives.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            idx = (int'(ptr) + j) % NREQ;
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    // Advance the pointer past the winner only when a transfer happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_en) begin
            if (grant_idx == PW'(NREQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

`endif

    // A grant is a transfer: req_ready is only raised for a valid requester.
    assign grant_en = run_q & arb_en & grant_any;

    // Grant vector and operand mux toward the shared multiplier.
    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (grant_en) begin
            req_ready = NREQ'(1) << grant_idx;
            mul_a     = req_a[16*grant_idx +: 16];
            mul_b     = req_b[16*grant_idx +: 16];
        end
    end

    // The pipeline never stalls once out of reset; its reset follows rst_n.
    assign mul_ce  = run_q;
    assign mul_rst = ~rst_n;

    // Shift the tag of each transfer alongside its product; reset discards
    // everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_vld[i] <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_vld[0] <= grant_en;
            tag_idx[0] <= grant_idx;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    // Steer the product to its originator when the last tag stage is valid.
    always_comb begin
        rsp_valid = '0;
        rsp_p     = '0;
        if (tag_vld[LAT-1]) begin
            rsp_valid = NREQ'(1) << tag_idx[LAT-1];
            rsp_p     = mul_p;
        end
    end

    // Busy while any product is still travelling through the pipeline.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | tag_vld[i];
        end
    end

endmodule

// File: tb/tb_mul16_share_arb.sv
// tb/tb_mul16_share_arb.sv - scoreboard bench for mul16_share_arb with a behavioural multiplier
`timescale 1ns/1ps

module tb_mul16_share_arb;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arb_en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic              mul_ce;
    logic              mul_rst;
    logic [15:0]       mul_a;
    logic [15:0]       mul_b;
    logic [31:0]       mul_p;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_p;
    logic              busy;

    logic [15:0]       op_a  [NREQ];
    logic [15:0]       op_b  [NREQ];
    logic [31:0]       exp_p [NREQ];

    typedef struct {
        int              due;
        logic [NREQ-1:0] rv;
        logic [31:0]     p;
    } exp_t;

    exp_t  sb [$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    mul16_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_rst   (mul_rst),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand packing.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = op_a[i];
            req_b[16*i +: 16] = op_b[i];
        end
    end

    // Behavioural LAT-stage multiplier: signed A times unsigned B.
    logic signed [32:0] prod_full;
    logic [31:0]        mstage [LAT];
    assign prod_full = $signed(mul_a) * $signed({1'b0, mul_b});
    assign mul_p     = mstage[LAT-1];

    always @(posedge clk) begin
        if (mul_rst) begin
            for (int i = 0; i < LAT; i++) mstage[i] <= '0;
        end else if (mul_ce) begin
            mstage[0] <= prod_full[31:0];
            for (int i = 1; i < LAT; i++) mstage[i] <= mstage[i-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every result strobe.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: got nothing expected %h for %b due cycle %0d", sb[0].p, sb[0].rv, sb[0].due);
            void'(sb.pop_front());
        end
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid %b rsp_p %h expected none at cycle %0d", rsp_valid, rsp_p, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
                chk("rsp_p", rsp_p, e.p);
                chk("rsp_latency", cyc, e.due);
            end
        end else begin
            chk("rsp_p_idle", rsp_p, 32'h0);
        end
    end

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
        op_a[i]  = a;
        op_b[i]  = b;
        exp_p[i] = p;
    endtask

    // One cycle of stimulus: drive, check the combinational grant and operand
    // mux, and queue the expected result when a grant is expected.
    task automatic cycle(input logic [NREQ-1:0] v, input logic en, input logic [NREQ-1:0] g, input bit push);
        exp_t e;
        int   gi;
        @(negedge clk);
        req_valid = v;
        arb_en    = en;
        #1;
        chk("req_ready", 32'(req_ready), 32'(g));
        gi = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
        if (gi >= 0) begin
            chk("mul_a", 32'(mul_a), 32'(op_a[gi]));
            chk("mul_b", 32'(mul_b), 32'(op_b[gi]));
            if (push) begin
                e.due = cyc + LAT;
                e.rv  = g;
                e.p   = exp_p[gi];
                sb.push_back(e);
            end
        end else begin
            chk("mul_a_idle", 32'(mul_a), 32'h0);
            chk("mul_b_idle", 32'(mul_b), 32'h0);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic reset_phase(input logic [NREQ-1:0] v);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = v;
        arb_en    = 1'b1;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_mul_ce", 32'(mul_ce), 32'h0);
            chk("rst_mul_rst", 32'(mul_rst), 32'h1);
            chk("rst_mul_a", 32'(mul_a), 32'h0);
            chk("rst_mul_b", 32'(mul_b), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 32'h0);
        chk("release_mul_rst", 32'(mul_rst), 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        arb_en    = 1'b0;
        req_valid = '0;
        set_op(0, 16'h0005, 16'h0007, 32'h0000_0023);
        set_op(1, 16'hFFFF, 16'hFFFF, 32'hFFFF_0001);
        set_op(2, 16'h8000, 16'h0002, 32'hFFFF_0000);
        set_op(3, 16'h1234, 16'h0010, 32'h0001_2340);

        reset_phase(4'b1111);

`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
        // Requesters 1 and 2 contend: 1 always wins.
        for (int k = 0; k < 6; k++) cycle(4'b0110, 1'b1, 4'b0010, 1'b1);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
        drain();
`else
        // All requesters contend: strict rotation from pointer 0.
        for (int k = 0; k < 8; k++) cycle(4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
        drain();
`endif

        // Single requester 0, a=-2, b=3, eight back-to-back transfers.
        set_op(0, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA);
        for (int k = 0; k < 8; k++) cycle(4'b0001, 1'b1, 4'b0001, 1'b1);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
        drain();

`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
        // Move the pointer to 3, then requesters 0 and 3 alternate with wrap.
        set_op(0, 16'h0005, 16'h0007, 32'h0000_0023);
        cycle(4'b0100, 1'b1, 4'b0100, 1'b1);
        cycle(4'b1001, 1'b1, 4'b1000, 1'b1);
        cycle(4'b1001, 1'b1, 4'b0001, 1'b1);
        cycle(4'b1001, 1'b1, 4'b1000, 1'b1);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
        drain();
`endif

        // Three transfers, then arb_en low: grants stop, results still arrive.
        for (int k = 0; k < 3; k++) cycle(4'b1000, 1'b1, 4'b1000, 1'b1);
        cycle(4'b1000, 1'b0, 4'b0000, 1'b0);
        chk("busy_inflight", 32'(busy), 32'h1);
        for (int k = 0; k < 4; k++) cycle(4'b1000, 1'b0, 4'b0000, 1'b0);
        drain();
        @(posedge clk);
        #1;
        chk("busy_drained", 32'(busy), 32'h0);
        req_valid = '0;
        arb_en    = 1'b1;

        // Two products in flight are discarded by reset.
        set_op(0, 16'h0003, 16'h0003, 32'h0000_0009);
        cycle(4'b0001, 1'b1, 4'b0001, 1'b0);
        cycle(4'b0001, 1'b1, 4'b0001, 1'b0);
        set_op(2, 16'h7FFF, 16'hFFFF, 32'h7FFE_8001);
        reset_phase(4'b0100);
        cycle(4'b0100, 1'b1, 4'b0100, 1'b1);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
        drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mul16_share_arb.md
MUL16_SHARE_ARB -- requirements
Module: mul16_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter LAT, default 3, multiplier latency in clocks from operand sample edge to valid product (1..5).
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port arb_en  input  1  high permits new grants; low blocks grants while in-flight products drain.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operand-valid.
REQ-007 SHALL have port req_ready  output  NREQ  per-requester grant, one-hot or zero.
REQ-008 SHALL have port req_a  input  16*NREQ  A operands, requester i at bits [16i+15:16i], signed.
REQ-009 SHALL have port req_b  input  16*NREQ  B operands, same packing, unsigned.
REQ-010 SHALL have port mul_ce  output  1  multiplier clock enable.
REQ-011 SHALL have port mul_rst  output  1  active-high multiplier reset.
REQ-012 SHALL have port mul_a / mul_b  output  16 each  operands to the multiplier.
REQ-013 SHALL have port mul_p  input  32  product from the multiplier.
REQ-014 SHALL have port rsp_valid  output  NREQ  one-hot result strobe for the originating requester.
REQ-015 SHALL have port rsp_p  output  32  product, valid when rsp_valid is nonzero.
REQ-016 SHALL have port busy  output  1  high while any product is in flight.

Function
REQ-017 Transfer SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high; req_ready SHALL be combinational from req_valid, arb_en and the priority pointer.
REQ-018 At most one req_ready bit SHALL be high per cycle; none when arb_en is low or req_valid is zero.
REQ-019 Round-robin: search SHALL start at pointer ptr, ascending with wrap NREQ-1 -> 0; after a transfer by i, ptr SHALL become (i+1) mod NREQ; ptr SHALL be unchanged when there is no transfer.
REQ-020 mul_a/mul_b SHALL equal the granted requester's operands in the transfer cycle and SHALL be 0 otherwise.
REQ-021 mul_ce SHALL be constant 1 out of reset, so the pipeline never stalls; mul_rst SHALL equal ~rst_n.
REQ-022 A LAT-deep tag shift register (valid bit plus requester index) SHALL record each transfer; at most one entry per stage.
REQ-023 The result of a transfer at edge k SHALL appear as rsp_valid[i]=1 with rsp_p=mul_p exactly LAT cycles later, for exactly one cycle; results SHALL have no backpressure.
REQ-024 When no tag is valid at the last stage, rsp_valid SHALL be 0 and rsp_p SHALL be 0.
REQ-025 Back-to-back transfers SHALL be accepted every cycle; throughput 1 product/clock.
REQ-026 busy SHALL be the OR of all tag valid bits; arb_en falling SHALL NOT drop in-flight results.
REQ-027 Requesters SHALL hold operands stable while req_valid is high and req_ready is low; the block SHALL NOT latch operands.

Reset
REQ-028 While rst_n is low: req_ready=0, rsp_valid=0, rsp_p=0, busy=0, mul_a=mul_b=0, mul_ce=0, mul_rst=1, ptr=0, all tags cleared.
REQ-029 Reset mid-operation SHALL discard all in-flight products; no rsp_valid SHALL pulse for operations issued before reset.
REQ-030 Reset release SHALL take effect synchronously on the first clk edge after rst_n rises; first grant is possible in that cycle.

Configuration
REQ-031 With macro MUL_SHARE_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and ptr SHALL be removed; without it, round-robin per REQ-019.

Verification
REQ-032 Single requester 0 valid for 8 cycles, a=-2 (0xFFFE), b=3 -> 8 transfers, rsp_valid=0001 each cycle from LAT cycles later, rsp_p=0xFFFFFFFA.
REQ-033 All 4 requesters valid continuously -> grant order 0,1,2,3,0,1,... ; each rsp_valid bit pulses once per 4 cycles with the matching product.
REQ-034 ptr=3, only requesters 0 and 3 valid -> grant 3, then 0 (wrap), then 3.
REQ-035 3 transfers issued, then arb_en=0 -> req_ready=0 from that cycle, all 3 results still delivered, busy falls after the last one.
REQ-036 rst_n asserted with 2 products in flight -> no rsp_valid during or after reset for them; after release with requester 2 valid, a=0x7FFF, b=0xFFFF -> rsp_p=0x7FFE8001 to requester 2.
REQ-037 Build with MUL_SHARE_ARB_FIXED_PRIO_EN, requesters 1 and 2 valid continuously -> requester 1 granted every cycle, requester 2 never.
